// File: rtl/ycbcr_to_rgb.sv
// ycbcr_to_rgb
// Pipelined inverse colour converter for the decode side of the compression IP.
// It reads YCbCr pixels back from the YCbCr frame buffer and produces 8-bit RGB.
// Pixels move through three register stages (S1 operands, S2 products, S3 clamped
// result) under one global advance enable. A frame counter tags the last pixel
// of every frame.
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 asynchronous active-high reset
//   Y_in/Cb_in/Cr_in    32-bit pixel components, only bits [7:0] are used
//   in_valid/in_ready   input handshake; in_ready = !(out_valid && !out_ready)
//   R_O/G_O/B_O         32-bit colour outputs, [7:0] result, [31:8] zero
//   out_valid/out_ready output handshake
//   out_last            output pixel is index FRAME_PIXELS-1 of its frame
//   pix_count           frame index of the pixel currently at the output
module ycbcr_to_rgb #(
    parameter int FRAC         = 14,
    parameter int FRAME_PIXELS = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Y_in,
    input  logic [31:0] Cb_in,
    input  logic [31:0] Cr_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] R_O,
    output logic [31:0] G_O,
    output logic [31:0] B_O,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [31:0] pix_count
);

    // Q2.14 coefficients: 1.402, 0.344136, 0.714136, 1.772
    localparam logic signed [25:0] KR       = 26'sd22970;
    localparam logic signed [25:0] KGB      = 26'sd5638;
    localparam logic signed [25:0] KGR      = 26'sd11700;
    localparam logic signed [25:0] KB       = 26'sd29032;
    // Half an LSB folded into the luma term so the final shift rounds to nearest
    localparam logic signed [25:0] ROUND    = 26'sd1 <<< (FRAC - 1);
    localparam logic [31:0]        LAST_IDX = 32'(FRAME_PIXELS - 1);

    // Sign-extend a 9-bit stage-1 operand to the 26-bit datapath width
    function automatic logic signed [25:0] sext9(input logic signed [8:0] v);
        return {{17{v[8]}}, v};
    endfunction

    // Saturate a signed shifted sum to the 0..255 pixel range
    function automatic logic [7:0] clamp8(input logic signed [25:0] v);
        logic [7:0] res;
        if (v < 26'sd0) begin
            res = 8'd0;
        end else if (v > 26'sd255) begin
            res = 8'd255;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

    logic               stall_s;
    logic               advance_s;
    logic               out_fire_s;
    logic               unused_upper_s;

    logic               s1_valid_q;
    logic               s2_valid_q;
    logic               s3_valid_q;

    logic signed [8:0]  y_q,  y_d;
    logic signed [8:0]  cb_q, cb_d;
    logic signed [8:0]  cr_q, cr_d;

    logic signed [25:0] ybase_q,  ybase_d;
    logic signed [25:0] kr_cr_q,  kr_cr_d;
    logic signed [25:0] kgb_cb_q, kgb_cb_d;
    logic signed [25:0] kgr_cr_q, kgr_cr_d;
    logic signed [25:0] kb_cb_q,  kb_cb_d;

    logic signed [25:0] r_sum_s;
    logic signed [25:0] g_sum_s;
    logic signed [25:0] b_sum_s;

    logic [7:0]         r_q, r_d;
    logic [7:0]         g_q, g_d;
    logic [7:0]         b_q, b_d;

    logic [31:0]        pix_count_q, pix_count_d;

    // The whole pipe freezes only when a valid output is refused downstream
    assign stall_s        = s3_valid_q & ~out_ready;
    assign advance_s      = ~stall_s;
    assign out_fire_s     = s3_valid_q & out_ready;
    assign unused_upper_s = ^{Y_in[31:8], Cb_in[31:8], Cr_in[31:8]};

    assign in_ready  = advance_s;
    assign out_valid = s3_valid_q;
    assign R_O       = {24'd0, r_q};
    assign G_O       = {24'd0, g_q};
    assign B_O       = {24'd0, b_q};
    assign pix_count = pix_count_q;
    assign out_last  = s3_valid_q & (pix_count_q == LAST_IDX);

    // S1 operands: luma as-is, chroma recentred around zero
    always_comb begin
        y_d  = $signed({1'b0, Y_in[7:0]});
        cb_d = $signed({1'b0, Cb_in[7:0]}) - 9'sd128;
        cr_d = $signed({1'b0, Cr_in[7:0]}) - 9'sd128;
    end

    // S2 products and rounded luma base
    always_comb begin
        ybase_d  = ($signed({17'd0, y_q}) <<< FRAC) + ROUND;
        kr_cr_d  = KR  * sext9(cr_q);
        kgb_cb_d = KGB * sext9(cb_q);
        kgr_cr_d = KGR * sext9(cr_q);
        kb_cb_d  = KB  * sext9(cb_q);
    end

    // S3 sums, arithmetic shift back to integer and saturation
    always_comb begin
        r_sum_s = ybase_q + kr_cr_q;
        g_sum_s = ybase_q - kgb_cb_q - kgr_cr_q;
        b_sum_s = ybase_q + kb_cb_q;
        r_d     = clamp8(r_sum_s >>> FRAC);
        g_d     = clamp8(g_sum_s >>> FRAC);
        b_d     = clamp8(b_sum_s >>> FRAC);
    end

    // Frame index of the next output pixel, wrapping at the frame end
    always_comb begin
        if (out_fire_s) begin
            if (pix_count_q == LAST_IDX) begin
                pix_count_d = 32'd0;
            end else begin
                pix_count_d = pix_count_q + 32'd1;
            end
        end else begin
            pix_count_d = pix_count_q;
        end
    end

    // Pipeline registers: all stages shift together whenever the output is not stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            y_q        <= 9'sd0;
            cb_q       <= 9'sd0;
            cr_q       <= 9'sd0;
            ybase_q    <= 26'sd0;
            kr_cr_q    <= 26'sd0;
            kgb_cb_q   <= 26'sd0;
            kgr_cr_q   <= 26'sd0;
            kb_cb_q    <= 26'sd0;
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            b_q        <= 8'd0;
        end else if (advance_s) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            y_q        <= y_d;
            cb_q       <= cb_d;
            cr_q       <= cr_d;
            ybase_q    <= ybase_d;
            kr_cr_q    <= kr_cr_d;
            kgb_cb_q   <= kgb_cb_d;
            kgr_cr_q   <= kgr_cr_d;
            kb_cb_q    <= kb_cb_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    // Output pixel frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_count_q <= 32'd0;
        end else begin
            pix_count_q <= pix_count_d;
        end
    end

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Self-checking bench for ycbcr_to_rgb.
// A second instance with FRAME_PIXELS=1 runs in lockstep on the same stimulus.
module tb_ycbcr_to_rgb;

    localparam int FP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Y_in, Cb_in, Cr_in;
    logic        in_valid, in_ready, out_ready, out_valid, out_last;
    logic [31:0] R_O, G_O, B_O, pix_count;
    logic        in_ready1, out_valid1, out_last1;
    logic [31:0] R1, G1, B1, pix_count1;

    int total = 0;
    int bad   = 0;
    logic [23:0] exp_q[$];
    int exp_idx = 0;

    typedef struct {
        logic [7:0] y, cb, cr, r, g, b;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    ycbcr_to_rgb #(.FRAC(14), .FRAME_PIXELS(FP)) dut (
        .clk(clk), .rst(rst), .Y_in(Y_in), .Cb_in(Cb_in), .Cr_in(Cr_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .R_O(R_O), .G_O(G_O), .B_O(B_O),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .pix_count(pix_count)
    );

    ycbcr_to_rgb #(.FRAC(14), .FRAME_PIXELS(1)) dut1 (
        .clk(clk), .rst(rst), .Y_in(Y_in), .Cb_in(Cb_in), .Cr_in(Cr_in),
        .in_valid(in_valid), .in_ready(in_ready1),
        .R_O(R1), .G_O(G1), .B_O(B1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_last(out_last1), .pix_count(pix_count1)
    );

    function automatic logic [7:0] sat(input int v);
        if (v < 0) return 8'd0;
        else if (v > 255) return 8'd255;
        else return 8'(v);
    endfunction

    // Reference conversion straight from the fixed-point formulas
    function automatic logic [23:0] ref_rgb(input int y, input int cb, input int cr);
        int yb, r, g, b;
        yb = y * 16384 + 8192;
        r  = (yb + 22970 * (cr - 128)) >>> 14;
        g  = (yb - 5638 * (cb - 128) - 11700 * (cr - 128)) >>> 14;
        b  = (yb + 29032 * (cb - 128)) >>> 14;
        return {sat(r), sat(g), sat(b)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard step, called once per cycle mid-period when everything is stable
    task automatic monitor();
        logic [23:0] e;
        if (rst == 1'b0) begin
            check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            check("in_ready_fp1", 32'(in_ready1), 32'(in_ready));
            check("valid_fp1", 32'(out_valid1), 32'(out_valid));
            if (in_valid && in_ready)
                exp_q.push_back(ref_rgb(int'(Y_in[7:0]), int'(Cb_in[7:0]), int'(Cr_in[7:0])));
            if (out_valid) begin
                check("last_fp1", 32'(out_last1), 32'd1);
                check("cnt_fp1", pix_count1, 32'd0);
                check("r_fp1", R1, R_O);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL unexpected_output: got an output pixel, expected none (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_r", R_O, {24'd0, e[23:16]});
                    check("out_g", G_O, {24'd0, e[15:8]});
                    check("out_b", B_O, {24'd0, e[7:0]});
                    check("out_cnt", pix_count, 32'(exp_idx));
                    check("out_last", 32'(out_last), 32'(exp_idx == FP - 1));
                    exp_idx = (exp_idx + 1) % FP;
                end
            end
        end
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_mid();
        @(negedge clk);
        monitor();
    endtask

    task automatic rand_pixel();
        Y_in  = $urandom;
        Cb_in = $urandom;
        Cr_in = $urandom;
    endtask

    // Wait (bounded) for out_valid after a single pixel was offered; returns cycles since acceptance
    task automatic wait_out(output int lat);
        tick_edge();
        in_valid = 1'b0;
        tick_mid();
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick_edge();
            tick_mid();
            lat = lat + 1;
        end
    endtask

    initial begin
        int   lat;
        int   accepted;
        int   ncyc;
        int   guard;
        logic took;

        vecs[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
        vecs[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd135, 8'd0};
        vecs[2] = '{8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0};
        vecs[3] = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255};

        // reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Y_in = 32'd0; Cb_in = 32'd0; Cr_in = 32'd0;
        tick_edge();
        tick_mid();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_r", R_O, 32'd0);
        check("rst_g", G_O, 32'd0);
        check("rst_b", B_O, 32'd0);
        check("rst_cnt", pix_count, 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick_edge();
        rst = 1'b0;
        tick_mid();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // table of known conversions, one pixel at a time
        for (int i = 0; i < 4; i++) begin
            tick_edge();
            Y_in  = {24'h5A5A5A, vecs[i].y};
            Cb_in = {24'hA5A5A5, vecs[i].cb};
            Cr_in = {24'hFFFFFF, vecs[i].cr};
            in_valid = 1'b1;
            tick_mid();
            wait_out(lat);
            check("vec_latency", 32'(lat), 32'd3);
            check("vec_r", R_O, {24'd0, vecs[i].r});
            check("vec_g", G_O, {24'd0, vecs[i].g});
            check("vec_b", B_O, {24'd0, vecs[i].b});
            check("vec_cnt", pix_count, 32'(i));
            check("vec_last", 32'(out_last), 32'(i == FP - 1));
        end

        // 10 pixels back to back: one output per cycle, frame wrap every 4
        for (int k = 0; k < 16; k++) begin
            tick_edge();
            if (k < 10) begin
                rand_pixel();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick_mid();
            check("b2b_valid", 32'(out_valid), 32'(k >= 3 && k < 13));
            if (k >= 3 && k < 13) begin
                check("b2b_cnt", pix_count, 32'((k - 3) % FP));
                check("b2b_last", 32'(out_last), 32'(((k - 3) % FP) == FP - 1));
            end
        end

        // 5-cycle downstream stall with the source still offering data
        took = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick_edge();
            if (took) rand_pixel();
            in_valid  = 1'b1;
            out_ready = !(c >= 5 && c < 10);
            tick_mid();
            if (c >= 5 && c < 10) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_cnt", pix_count, 32'(exp_idx));
                if (exp_q.size() > 0) begin
                    check("stall_r", R_O, {24'd0, exp_q[0][23:16]});
                    check("stall_g", G_O, {24'd0, exp_q[0][15:8]});
                    check("stall_b", B_O, {24'd0, exp_q[0][7:0]});
                end else begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL stall_queue: got no pending pixel, expected one (t=%0t)", $time);
                end
            end
            took = in_valid && in_ready;
        end
        tick_edge();
        in_valid = 1'b0; out_ready = 1'b1;
        tick_mid();
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick_edge();
            tick_mid();
            guard = guard + 1;
        end
        check("stall_drain", 32'(exp_q.size()), 32'd0);

        // bring the frame index to 1 so the reset visibly clears it
        guard = 0;
        while (exp_idx != 1 && guard < 8) begin
            tick_edge();
            rand_pixel();
            in_valid = 1'b1;
            tick_mid();
            wait_out(lat);
            guard = guard + 1;
        end
        check("pre_rst_idx", 32'(exp_idx), 32'd1);

        // reset with 3 pixels in flight
        for (int i = 0; i < 3; i++) begin
            tick_edge();
            rand_pixel();
            in_valid = 1'b1;
            tick_mid();
        end
        tick_edge();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_cnt", pix_count, 32'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_cnt", pix_count, 32'd0);
        check("midrst_r", R_O, 32'd0);
        check("midrst_last", 32'(out_last), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        tick_mid();
        exp_q.delete();
        exp_idx = 0;
        tick_edge();
        rst = 1'b0;
        rand_pixel();
        in_valid = 1'b1;
        tick_mid();
        wait_out(lat);
        check("after_rst_latency", 32'(lat), 32'd3);
        check("after_rst_cnt", pix_count, 32'd0);

        // random handshakes, 1000 pixels against the reference model
        accepted = 0;
        ncyc = 0;
        took = 1'b0;
        in_valid = 1'b0;
        while (accepted < 1000 && ncyc < 20000) begin
            tick_edge();
            if (took || !in_valid) begin
                rand_pixel();
                in_valid = ($urandom_range(0, 9) < 7);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick_mid();
            took = in_valid && in_ready;
            if (took) accepted = accepted + 1;
            ncyc = ncyc + 1;
        end
        check("rand_accepted", 32'(accepted), 32'd1000);
        tick_edge();
        in_valid = 1'b0; out_ready = 1'b1;
        tick_mid();
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick_edge();
            tick_mid();
            guard = guard + 1;
        end
        check("rand_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
